// File: rtl/slink_rx_train_ctrl.sv
// ---------------------------------------------------------------------------
// slink_rx_train_ctrl
//
// Receive-side link training sequencer for the S-Link RX path. Drives the
// enable of slink_rx_deskew and walks the link through lock, TS1, TS2 and
// SDS phases by counting all-lane ordered-set detections, raising link_up
// once an SDS arrives. Handles lane-count changes, loss of lock in LINK_UP
// and remote retrain requests (TS1 seen while up).
//
// Optional feature macro: SLINK_RX_TRAIN_TIMEOUT_EN
//   defined   -> a per-state timeout counter is built; a training state that
//                makes no progress for TIMEOUT_CYCLES cycles goes to ERROR.
//   undefined -> no timeout logic; training waits indefinitely, and the only
//                way into ERROR is loss of lock while in LINK_UP.
//
// Ports:
//   clk            clock
//   reset          asynchronous, active-high reset
//   start          level; high requests training / keeps the link up
//   active_lanes   lane-count code (1<<code lanes), captured on training start
//   deskew_state   deskew state: 0 IDLE, 1 TRAIN, 2 LOCKED
//   rx_ts1_seen    per-lane TS1 detection pulses
//   rx_ts2_seen    per-lane TS2 detection pulses
//   rx_sds_seen    per-lane SDS detection pulses
//   deskew_enable  enable to the deskew block (registered)
//   link_up        high while in LINK_UP (registered)
//   train_error    high while in ERROR (registered)
//   train_state    current state encoding (registered)
//   ts_count       current TS1/TS2 count, 0 in other states (registered)
// ---------------------------------------------------------------------------
module slink_rx_train_ctrl #(
  parameter int NUM_LANES      = 4,
  parameter int TS1_TARGET     = 8,
  parameter int TS2_TARGET     = 8,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [2:0]           active_lanes,
  input  logic [1:0]           deskew_state,
  input  logic [NUM_LANES-1:0] rx_ts1_seen,
  input  logic [NUM_LANES-1:0] rx_ts2_seen,
  input  logic [NUM_LANES-1:0] rx_sds_seen,
  output logic                 deskew_enable,
  output logic                 link_up,
  output logic                 train_error,
  output logic [2:0]           train_state,
  output logic [7:0]           ts_count
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_LOCK = 3'd1,
    TS1       = 3'd2,
    TS2       = 3'd3,
    WAIT_SDS  = 3'd4,
    LINK_UP   = 3'd5,
    ERROR     = 3'd6
  } state_t;

  localparam logic [1:0] DESKEW_LOCKED = 2'd2;
  localparam logic [7:0] TS1_LAST      = 8'(TS1_TARGET - 1);
  localparam logic [7:0] TS2_LAST      = 8'(TS2_TARGET - 1);

  state_t     state_q;
  state_t     state_d;
  logic [7:0] ts_d;
  logic [2:0] lanes_q;
  logic [2:0] lanes_d;
  logic       to_restart;
  logic       timeout_hit;

  // Inactive lanes already report 1, so a plain AND across all lanes gives
  // the "every active lane saw it" event.
  logic ts1_all;
  logic ts2_all;
  logic sds_all;
  assign ts1_all = &rx_ts1_seen;
  assign ts2_all = &rx_ts2_seen;
  assign sds_all = &rx_sds_seen;

`ifdef SLINK_RX_TRAIN_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt;
  logic            to_counting;

  assign to_counting = (state_d == WAIT_LOCK) || (state_d == TS1) ||
                       (state_d == TS2) || (state_d == WAIT_SDS);
  assign timeout_hit = (to_cnt == TO_LAST);

  // Timeout counter: restarts on any state change or progress event and
  // sits at zero outside the training states. It never needs to wrap since
  // hitting the last value forces ERROR, which clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt <= '0;
    end else if ((state_d != state_q) || to_restart || !to_counting) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^{TO_LAST, to_restart};
  assign timeout_hit        = 1'b0;
`endif

  // Next-state logic. Global exits (start dropped, lane count changed,
  // timeout) outrank the per-state rules in every non-IDLE state.
  always_comb begin
    state_d    = state_q;
    ts_d       = ts_count;
    lanes_d    = lanes_q;
    to_restart = 1'b0;

    if (state_q == IDLE) begin
      if (start) begin
        state_d = WAIT_LOCK;
        lanes_d = active_lanes;
      end
    end else if (!start) begin
      state_d = IDLE;
    end else if (active_lanes != lanes_q) begin
      // Passing through IDLE drops deskew_enable for a cycle, which resets
      // the deskew block before it retrains on the new lane set.
      state_d = IDLE;
    end else if (timeout_hit) begin
      state_d = ERROR;
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          if (deskew_state == DESKEW_LOCKED) state_d = TS1;
        end
        TS1: begin
          // TS1 wins over a simultaneous TS2.
          if (ts1_all) begin
            to_restart = 1'b1;
            if (ts_count == TS1_LAST) state_d = TS2;
            else if (ts_count != 8'hFF) ts_d = ts_count + 8'd1;
          end else if (ts2_all) begin
            state_d = TS2;
          end
        end
        TS2: begin
          if (ts1_all) begin
            state_d = TS1;
          end else if (ts2_all) begin
            to_restart = 1'b1;
            if (ts_count == TS2_LAST) state_d = WAIT_SDS;
            else if (ts_count != 8'hFF) ts_d = ts_count + 8'd1;
          end
        end
        WAIT_SDS: begin
          // Lock is deliberately not checked here; a loss of lock that
          // coincides with SDS is caught from LINK_UP one cycle later.
          if (sds_all) state_d = LINK_UP;
          else if (ts1_all) state_d = TS1;
          else if (ts2_all) to_restart = 1'b1;
        end
        LINK_UP: begin
          if (deskew_state != DESKEW_LOCKED) state_d = ERROR;
          else if (ts1_all) state_d = TS1;
        end
        ERROR: begin
          state_d = ERROR;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    // The TS counter only has meaning inside TS1/TS2 and restarts from zero
    // whenever one of those states is (re)entered.
    if ((state_d != state_q) || !((state_d == TS1) || (state_d == TS2))) begin
      ts_d = 8'd0;
    end
  end

  // State, captured lane code and all outputs. Outputs are decoded from the
  // next state so they line up with the state register after each edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      lanes_q       <= 3'd0;
      ts_count      <= 8'd0;
      deskew_enable <= 1'b0;
      link_up       <= 1'b0;
      train_error   <= 1'b0;
      train_state   <= 3'd0;
    end else begin
      state_q       <= state_d;
      lanes_q       <= lanes_d;
      ts_count      <= ts_d;
      deskew_enable <= (state_d == WAIT_LOCK) || (state_d == TS1) ||
                       (state_d == TS2) || (state_d == WAIT_SDS) ||
                       (state_d == LINK_UP);
      link_up       <= (state_d == LINK_UP);
      train_error   <= (state_d == ERROR);
      train_state   <= state_d;
    end
  end

endmodule

// File: tb/tb_slink_rx_train_ctrl.sv
// ---------------------------------------------------------------------------
// tb_slink_rx_train_ctrl
//
// Directed self-checking bench for slink_rx_train_ctrl. Inputs change 1 ns
// after a rising edge and outputs are sampled at that same point, so each
// applyStimulus call of n cycles shows the effect of n edges.
// ---------------------------------------------------------------------------
module tb_slink_rx_train_ctrl;

  localparam int NL = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [2:0]    active_lanes;
  logic [1:0]    deskew_state;
  logic [NL-1:0] rx_ts1_seen;
  logic [NL-1:0] rx_ts2_seen;
  logic [NL-1:0] rx_sds_seen;
  logic          deskew_enable;
  logic          link_up;
  logic          train_error;
  logic [2:0]    train_state;
  logic [7:0]    ts_count;

  int checks = 0;
  int errors = 0;

  slink_rx_train_ctrl #(
    .NUM_LANES(NL),
    .TS1_TARGET(8),
    .TS2_TARGET(8),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .active_lanes(active_lanes),
    .deskew_state(deskew_state),
    .rx_ts1_seen(rx_ts1_seen),
    .rx_ts2_seen(rx_ts2_seen),
    .rx_sds_seen(rx_sds_seen),
    .deskew_enable(deskew_enable),
    .link_up(link_up),
    .train_error(train_error),
    .train_state(train_state),
    .ts_count(ts_count)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Checks the full visible output set against hand-computed values.
  task automatic checkAll(input string tag, input int st, input int de,
                          input int lu, input int te, input int tsc);
    checkOutput({tag, ".state"}, 32'(train_state), st);
    checkOutput({tag, ".deskew_enable"}, 32'(deskew_enable), de);
    checkOutput({tag, ".link_up"}, 32'(link_up), lu);
    checkOutput({tag, ".train_error"}, 32'(train_error), te);
    checkOutput({tag, ".ts_count"}, 32'(ts_count), tsc);
  endtask

  // Holds the given deskew state and ordered-set pulses for n edges, then
  // clears the pulses.
  task automatic applyStimulus(input logic [1:0] ds, input logic t1,
                               input logic t2, input logic s, input int n);
    deskew_state = ds;
    rx_ts1_seen  = {NL{t1}};
    rx_ts2_seen  = {NL{t2}};
    rx_sds_seen  = {NL{s}};
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
    rx_ts1_seen = '0;
    rx_ts2_seen = '0;
    rx_sds_seen = '0;
  endtask

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    active_lanes = 3'd2;
    deskew_state = 2'd0;
    rx_ts1_seen  = '0;
    rx_ts2_seen  = '0;
    rx_sds_seen  = '0;

    // Reset state.
    #12;
    checkAll("reset", 0, 0, 0, 0, 0);
    reset = 1'b0;
    applyStimulus(2'd0, 0, 0, 0, 1);
    checkAll("idle_hold", 0, 0, 0, 0, 0);

    // Nominal training.
    start = 1'b1;
    applyStimulus(2'd1, 0, 0, 0, 1);
    checkAll("wait_lock_entry", 1, 1, 0, 0, 0);
    applyStimulus(2'd1, 0, 0, 0, 4);
    checkAll("wait_lock_hold", 1, 1, 0, 0, 0);
    applyStimulus(2'd2, 0, 0, 0, 1);
    checkAll("ts1_entry", 2, 1, 0, 0, 0);
    for (int i = 1; i <= 7; i++) begin
      applyStimulus(2'd2, 1, 0, 0, 1);
      checkOutput("ts1_count", 32'(ts_count), i);
    end
    applyStimulus(2'd2, 0, 0, 0, 1);
    checkAll("ts1_idle_cycle", 2, 1, 0, 0, 7);
    applyStimulus(2'd2, 1, 0, 0, 1);
    checkAll("ts2_entry", 3, 1, 0, 0, 0);
    applyStimulus(2'd2, 0, 1, 0, 7);
    checkAll("ts2_count", 3, 1, 0, 0, 7);
    applyStimulus(2'd2, 0, 1, 0, 1);
    checkAll("wait_sds_entry", 4, 1, 0, 0, 0);
    applyStimulus(2'd2, 0, 1, 0, 1);
    checkAll("wait_sds_ts2_stays", 4, 1, 0, 0, 0);
    applyStimulus(2'd2, 0, 0, 1, 1);
    checkAll("link_up", 5, 1, 1, 0, 0);
    applyStimulus(2'd2, 0, 0, 0, 3);
    checkAll("link_up_hold", 5, 1, 1, 0, 0);

    // Remote retrain from LINK_UP, including TS1+TS2 in the same cycle.
    applyStimulus(2'd2, 1, 0, 0, 1);
    checkAll("retrain_entry", 2, 1, 0, 0, 0);
    applyStimulus(2'd2, 1, 0, 0, 1);
    checkAll("retrain_first", 2, 1, 0, 0, 1);
    applyStimulus(2'd2, 1, 1, 0, 1);
    checkAll("ts1_ts2_same_cycle", 2, 1, 0, 0, 2);
    applyStimulus(2'd2, 1, 0, 0, 6);
    checkAll("retrain_to_ts2", 3, 1, 0, 0, 0);
    applyStimulus(2'd2, 0, 1, 0, 8);
    applyStimulus(2'd2, 0, 0, 1, 1);
    checkAll("relink_up", 5, 1, 1, 0, 0);

    // Loss of lock while up, ERROR hold, exit on start low.
    applyStimulus(2'd0, 0, 0, 0, 1);
    checkAll("lock_loss", 6, 0, 0, 1, 0);
    applyStimulus(2'd0, 0, 0, 0, 1);
    checkAll("error_hold", 6, 0, 0, 1, 0);
    start = 1'b0;
    applyStimulus(2'd0, 0, 0, 0, 1);
    checkAll("error_exit", 0, 0, 0, 0, 0);

    // TS2 ahead in TS1, TS1 back from TS2, then a lane change in TS2.
    active_lanes = 3'd2;
    start        = 1'b1;
    applyStimulus(2'd2, 0, 0, 0, 1);
    checkAll("b_wait_lock", 1, 1, 0, 0, 0);
    applyStimulus(2'd2, 0, 0, 0, 1);
    checkAll("b_ts1", 2, 1, 0, 0, 0);
    applyStimulus(2'd2, 0, 1, 0, 1);
    checkAll("ts2_ahead", 3, 1, 0, 0, 0);
    applyStimulus(2'd2, 0, 1, 0, 3);
    checkAll("b_ts2_count", 3, 1, 0, 0, 3);
    applyStimulus(2'd2, 1, 0, 0, 1);
    checkAll("ts2_back_to_ts1", 2, 1, 0, 0, 0);
    applyStimulus(2'd2, 1, 0, 0, 8);
    applyStimulus(2'd2, 0, 1, 0, 2);
    checkAll("b_ts2_again", 3, 1, 0, 0, 2);
    active_lanes = 3'd1;
    applyStimulus(2'd1, 0, 0, 0, 1);
    checkAll("lane_change_idle", 0, 0, 0, 0, 0);
    applyStimulus(2'd1, 0, 0, 0, 1);
    checkAll("lane_change_relock", 1, 1, 0, 0, 0);
    applyStimulus(2'd1, 0, 0, 0, 1);
    checkAll("lane_change_stable", 1, 1, 0, 0, 0);

    // SDS coinciding with loss of lock in WAIT_SDS.
    applyStimulus(2'd2, 0, 0, 0, 1);
    applyStimulus(2'd2, 1, 0, 0, 8);
    applyStimulus(2'd2, 0, 1, 0, 8);
    checkAll("c_wait_sds", 4, 1, 0, 0, 0);
    applyStimulus(2'd0, 0, 0, 1, 1);
    checkAll("sds_with_lock_loss", 5, 1, 1, 0, 0);
    applyStimulus(2'd0, 0, 0, 0, 1);
    checkAll("late_lock_loss", 6, 0, 0, 1, 0);
    start = 1'b0;
    applyStimulus(2'd0, 0, 0, 0, 1);

    // Asynchronous reset in the middle of TS1 with ts_count at 5.
    start = 1'b1;
    applyStimulus(2'd2, 0, 0, 0, 2);
    applyStimulus(2'd2, 1, 0, 0, 5);
    checkAll("pre_reset", 2, 1, 0, 0, 5);
    #2;
    reset = 1'b1;
    #1;
    checkAll("async_reset", 0, 0, 0, 0, 0);
    reset = 1'b0;
    #1;
    checkAll("after_reset", 0, 0, 0, 0, 0);
    applyStimulus(2'd1, 0, 0, 0, 1);
    checkAll("retrain_from_idle", 1, 1, 0, 0, 0);

    // Timeout from WAIT_LOCK (64-cycle budget) or indefinite wait.
    applyStimulus(2'd1, 0, 0, 0, 63);
`ifdef SLINK_RX_TRAIN_TIMEOUT_EN
    checkAll("timeout_edge_minus1", 1, 1, 0, 0, 0);
    applyStimulus(2'd1, 0, 0, 0, 1);
    checkAll("timeout_error", 6, 0, 0, 1, 0);
    start = 1'b0;
    applyStimulus(2'd1, 0, 0, 0, 1);
    checkAll("timeout_clear", 0, 0, 0, 0, 0);
`else
    applyStimulus(2'd1, 0, 0, 0, 40);
    checkAll("no_timeout", 1, 1, 0, 0, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
